// File: rtl/seven_seg_pkg.sv
// Shared seven-segment glyph constants and limits for the scan driver.
// Segment bit order is {g,f,e,d,c,b,a}; a set bit lights the segment.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int MAX_DIGITS = 8;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_hex_rom.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module seven_seg_hex_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit hex display driver with tear-free frame-boundary commit.
// Define SEVEN_SEG_LZB_EN to blank leading zero digits (digit 0 never blanked).
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam seg_t                  SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("NUM_DIGITS out of range");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("REFRESH_DIV must be at least 2");
  end

  logic [PRE_W-1:0]                presc_q, presc_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]           pend_dp_q, pend_dp_d;
  logic                            pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0][3:0]      disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]           disp_dp_q, disp_dp_d;
  logic                            first_q, first_d;
  logic                            wrap_q, wrap_d;
  logic                            frame_done_q, frame_done_d;
  seg_t                            seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;

  logic                            run;
  logic                            presc_tc;
  logic                            wrap;
  logic [3:0]                      cur_nib;
  logic                            cur_dp;
  logic                            cur_blank;
  logic [NUM_DIGITS-1:0]           an_raw;
  seg_t                            rom_seg;
  seg_t                            seg_raw;
`ifdef SEVEN_SEG_LZB_EN
  logic [NUM_DIGITS:0]             lz;
`endif

  // first_q holds the scan still for one cycle after reset so outputs stay
  // dark that cycle and digit 0 still gets its full REFRESH_DIV on-time.
  assign run      = !first_q;
  assign presc_tc = (presc_q == PRE_LAST);
  assign wrap     = run && presc_tc && (idx_q == IDX_LAST);

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    first_d      = 1'b0;
    wrap_d       = first_q ? 1'b1 : wrap;
    frame_done_d = wrap_q && !first_q;

    if (run) begin
      presc_d = presc_tc ? '0 : presc_q + 1'b1;
      if (presc_tc) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end

    // A strobe landing exactly on the wrap goes straight to the display.
    if (load && wrap) begin
      disp_val_d = value;
      disp_dp_d  = dp_in;
      pend_vld_d = 1'b0;
    end else begin
      if (wrap && pend_vld_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
        pend_vld_d = 1'b0;
      end
      if (load) begin
        pend_val_d = value;
        pend_dp_d  = dp_in;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_raw    = '0;
`ifdef SEVEN_SEG_LZB_EN
    lz             = '0;
    lz[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_val_q[i] == 4'h0);
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_val_q[i];
        cur_dp    = disp_dp_q[i];
        an_raw[i] = 1'b1;
`ifdef SEVEN_SEG_LZB_EN
        cur_blank = (i > 0) && lz[i];
`endif
      end
    end
  end

  seven_seg_hex_rom u_rom (
    .nib (cur_nib),
    .seg (rom_seg)
  );

  assign seg_raw = cur_blank ? SEG_BLANK : rom_seg;

  // Polarity is applied last; the post-reset cycle drives the dark pattern.
  always_comb begin
    seg_d = seg_raw ^ SEG_INV;
    dp_d  = cur_dp ^ DP_INV;
    an_d  = an_raw ^ AN_INV;
    if (first_q) begin
      seg_d = SEG_INV;
      dp_d  = DP_INV;
      an_d  = AN_INV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      first_q      <= 1'b1;
      wrap_q       <= 1'b1;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_INV;
      dp_q         <= DP_INV;
      an_q         <= AN_INV;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      first_q      <= first_d;
      wrap_q       <= wrap_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: table of loads checked frame-by-frame
// through an expectation queue, plus tear-free, bypass and mid-frame reset cases.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;

`ifdef SEVEN_SEG_LZB_EN
  localparam logic [6:0] LZ0 = 7'h00;
`else
  localparam logic [6:0] LZ0 = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst, rst2, load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, fd, fd2;
  logic [3:0]  an, an2;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD),
                          .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_done(fd)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD),
                          .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
    .clk(clk), .rst(rst2), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg2), .dp(dp2), .an(an2), .frame_done(fd2)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input int which, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (((which == 0) ? fd : fd2) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no frame_done on dut %0d within 64 cycles", which);
    end
  endtask

  task automatic push_digits(input logic [3:0][6:0] s, input logic [3:0] d, input bit inv);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.an  = 4'b0001 << i;
      e.seg = s[i];
      e.dp  = d[i];
      if (inv) e = ~e;
      sb.push_back(e);
    end
  endtask

  // Checks one whole frame starting at its frame_done cycle; optionally
  // strobes load at frame-relative cycles lk1/lk2 while checking.
  task automatic check_frame(input int which, input int lk1, input logic [15:0] lv1,
                             input int lk2, input logic [15:0] lv2);
    bit   ok;
    exp_t e, a;
    e = '0;
    wait_frame(which, ok);
    for (int k = 0; k < N * RD; k++) begin
      if (k > 0) @(negedge clk);
      if (k % RD == 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: frame cycle %0d has no expectation", k);
        end else begin
          e = sb.pop_front();
        end
      end
      a = (which == 0) ? {an, seg, dp} : {an2, seg2, dp2};
      chk($sformatf("dut%0d_k%0d_an", which, k), a.an, e.an);
      chk($sformatf("dut%0d_k%0d_seg", which, k), a.seg, e.seg);
      chk($sformatf("dut%0d_k%0d_dp", which, k), a.dp, e.dp);
      chk($sformatf("dut%0d_k%0d_frame_done", which, k),
          (which == 0) ? fd : fd2, (k == 0));
      load  = (k == lk1) || (k == lk2);
      value = (k == lk1) ? lv1 : lv2;
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit found;
    rst = 1'b1; rst2 = 1'b1; load = 1'b0; value = '0; dp_in = '0;

    vecs[0] = '{value: 16'h12AF, dp: 4'b0100, segs: {7'h06, 7'h5B, 7'h77, 7'h71}};
    vecs[1] = '{value: 16'h3456, dp: 4'b1001, segs: {7'h4F, 7'h66, 7'h6D, 7'h7D}};
    vecs[2] = '{value: 16'h789B, dp: 4'b0000, segs: {7'h07, 7'h7F, 7'h6F, 7'h7C}};
    vecs[3] = '{value: 16'hCDE0, dp: 4'b1111, segs: {7'h39, 7'h5E, 7'h79, 7'h3F}};
    vecs[4] = '{value: 16'h0050, dp: 4'b0010, segs: {LZ0, LZ0, 7'h6D, 7'h3F}};
    vecs[5] = '{value: 16'h0100, dp: 4'b0001, segs: {LZ0, 7'h06, 7'h3F, 7'h3F}};
    vecs[6] = '{value: 16'h0000, dp: 4'b1000, segs: {LZ0, LZ0, LZ0, 7'h3F}};

    // Reset: dark outputs while held and for the first released cycle.
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", an, 4'b0000);
      chk("rst_seg", seg, 7'h00);
      chk("rst_dp", dp, 1'b0);
      chk("rst_frame_done", fd, 1'b0);
      chk("rst_inv_an", an2, 4'b1111);
      chk("rst_inv_seg", seg2, 7'h7F);
    end
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("rel0_an", an, 4'b0000);
    chk("rel0_seg", seg, 7'h00);
    chk("rel0_frame_done", fd, 1'b0);
    @(negedge clk);
    chk("rel1_an", an, 4'b0001);
    chk("rel1_seg", seg, 7'h3F);
    chk("rel1_frame_done", fd, 1'b1);
    chk("rel1_inv_an", an2, 4'b1110);
    chk("rel1_inv_seg", seg2, 7'h40);

    // Table: load mid-frame, check the frame after commit.
    foreach (vecs[v]) begin
      wait_frame(0, ok);
      load = 1'b1; value = vecs[v].value; dp_in = vecs[v].dp;
      @(negedge clk);
      load = 1'b0; dp_in = '0;
      push_digits(vecs[v].segs, vecs[v].dp, 1'b0);
      check_frame(0, -1, '0, -1, '0);
    end

    // Tear-free: two mid-frame loads; old value holds, only the last commits.
    push_digits(vecs[6].segs, vecs[6].dp, 1'b0);
    check_frame(0, 1, 16'h1111, 3, 16'h2222);
    push_digits({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, 1'b0);
    check_frame(0, -1, '0, -1, '0);

    // Load exactly on the wrap cycle bypasses the earlier pending value.
    push_digits({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, 1'b0);
    check_frame(0, 2, 16'h3333, 14, 16'h0F0F);
    push_digits({LZ0, 7'h71, 7'h3F, 7'h71}, 4'b0000, 1'b0);
    check_frame(0, -1, '0, -1, '0);
    push_digits({LZ0, 7'h71, 7'h3F, 7'h71}, 4'b0000, 1'b0);
    check_frame(0, -1, '0, -1, '0);

    // Inverted-polarity instance: 8888 lights every segment, so seg reads 0.
    wait_frame(1, ok);
    load = 1'b1; value = 16'h8888; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    push_digits({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, 1'b1);
    check_frame(1, -1, '0, -1, '0);

    // Mid-digit-2 reset with a load pending: pending must be discarded.
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an2 === 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL digit2_timeout: an2 never showed digit 2, last %b", an2);
    end
    load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0; rst2 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_an", an2, 4'b1111);
      chk("midrst_seg", seg2, 7'h7F);
      chk("midrst_dp", dp2, 1'b1);
      chk("midrst_frame_done", fd2, 1'b0);
    end
    rst2 = 1'b0;
    @(negedge clk);
    chk("midrst_rel0_an", an2, 4'b1111);
    chk("midrst_rel0_seg", seg2, 7'h7F);
    push_digits({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b1);
    check_frame(1, -1, '0, -1, '0);
    push_digits({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b1);
    check_frame(1, -1, '0, -1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It latches a packed hex value on a load strobe and commits it tear-free at frame boundaries. It scans one digit per refresh period and emits registered segment, decimal-point and anode-select outputs. It sits between the datapath producing numeric results and the board display pins, and extends single-digit BCD decoding to full hex, multi-digit scanning and per-digit decimal points.

## Interface
Parameters:
- NUM_DIGITS, 4, digits scanned; legal 1..8; digit 0 is least significant.
- REFRESH_DIV, 1000, clk cycles each digit is held; legal >= 2.
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the output register.
- AN_ACTIVE_LOW, 0, 1 inverts an at the output register.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  strobe: capture value and dp_in this cycle.
- value  in  4*NUM_DIGITS  packed nibbles; nibble i drives digit i.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- seg  out  7  {g,f,e,d,c,b,a}; bit 0 = a.
- dp  out  1  decimal point of the active digit.
- an  out  NUM_DIGITS  one-hot digit enable.
- frame_done  out  1  one-cycle pulse on each frame wrap.

## Operation
- Prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances: 0,1,…,NUM_DIGITS-1,0.
- An index wrap from NUM_DIGITS-1 to 0 is a frame wrap. frame_done is asserted in the cycle after the wrap, aligned with digit 0 appearing on the outputs.
- On load, value and dp_in go into a pending register and pending_valid is set. If multiple loads occur in one frame, the last one wins.
- At frame wrap with pending_valid, the pending contents are copied to the display register and pending_valid is cleared.
- If load coincides with a frame wrap, the strobed value bypasses pending, goes directly to the display register, and pending_valid is cleared.
- Decode for 0-F, as hex codes: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (A,b,C,d,E,F glyphs).
- Outputs are registered from the current index and display register: an = one-hot(index), seg = decode(nibble[index]), dp = dp_reg[index]. Polarity inversion is applied last.
- Reset clears prescaler, index, pending, pending_valid, display register and frame_done. It also drives seg = blank, dp = off and an = all off (all at inactive polarity) for the reset cycle and the first cycle after rst falls.
- If reset is asserted mid-frame, it aborts any pending load; the pending value is discarded.

## Timing
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. Each an bit is active for exactly REFRESH_DIV consecutive cycles per frame.
- The first post-reset digit 0 appears 1 cycle after rst deasserts.
- Load-to-visible latency is at most one frame period + 1 cycle and at least 1 cycle (bypass case).
- Index width is max(1,$clog2(NUM_DIGITS)). Prescaler width is $clog2(REFRESH_DIV). Neither counter may exceed its terminal value.
- For NUM_DIGITS=1, an is held at 1 and every prescaler wrap is a frame wrap.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking. Digit i>0 shows blank (seg all off) when nibble i and all more-significant nibbles are 0. Digit 0 is never blanked. dp is unaffected, and an still scans.
- Not defined: all digits always show their decoded nibble, including leading zeros.

## Structure
- Package seven_seg_pkg holds:
  - the SEG_0..SEG_F and SEG_BLANK 7-bit constants,
  - the seg_t typedef (logic [6:0]),
  - the MAX_DIGITS=8 constant.
- Sub-module seven_seg_hex_rom is a combinational nibble-to-seg_t lookup, instantiated once on the indexed nibble.

## Test plan
Directed scenarios, using NUM_DIGITS=4 and REFRESH_DIV=4 unless noted.

- Reset: hold rst 3 cycles, then release. Required: an=0000 and seg=0000000 through release+0. At release+1, an=0001, seg=3F, and frame_done pulses.
- Scan: load 16'h12AF with dp_in=4'b0100, then run 2 frames. Required, starting the frame after commit with each digit held 4 cycles: an=0001/seg=71, an=0010/seg=77, an=0100/seg=5B/dp=1, an=1000/seg=06.
- Tear-free: load 16'h1111 mid-frame, then 16'h2222 two cycles later. Required: the old value is shown until the wrap; only 2222 ever appears after it, never 1111.
- Coincident load and wrap: strobe load with 16'h0F0F in the exact frame-wrap cycle. Required: digit 0 shows 71 in the very next cycle.
- LZB: with SEVEN_SEG_LZB_EN, load 16'h0050. Required: digits 3 and 2 are blank, digit 1 is 6D, digit 0 is 3F. Without the macro, digits 3 and 2 show 3F.
- Polarity and mid-frame reset: with SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1, load 16'h8888 and assert rst mid-digit-2. Required: seg=0000000 while digits scan, and after reset an=1111 with seg=1111111, display register 0.
